demux_steer_ctl: RTL and testbench

- Clocked steering controller for the two-way four-phase async demux.
- Accepts routing tokens (destination 0 or 1) from a synchronous requester and buffers them in a small FIFO.
- For each token, runs one full four-phase cycle on the demux control inputs: raises ctl_a or ctl_b, waits for the control acknowledge, releases, waits for the acknowledge to fall.
- Keeps per-destination transfer counts and a sticky handshake-timeout flag.

---
 rtl/demux_steer_ctl.sv | 91 +++++++++
 tb/tb_demux_steer_ctl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_steer_ctl.sv
// demux_steer_ctl: buffers routing tokens and runs one four-phase handshake per token
// on the ctl_a/ctl_b control inputs of a two-way async demux.
module demux_steer_ctl #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  input  logic             tok_dst,
  output logic             tok_ready,
  output logic             ctl_a,
  output logic             ctl_b,
  input  logic             actl_i,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             err,
  input  logic             err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t state, state_d;
  logic [DEPTH-1:0] mem;
  logic [AW:0] wp, rp;
  logic [SYNC-1:0] sync_q;
  logic [PW-1:0] ph;
  logic ack_s, empty, full, head, push, pop, hs, ctl_a_d, ctl_b_d;
  assign ack_s = sync_q[SYNC-1];
  assign empty = wp == rp;
  assign full = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
  assign head = mem[rp[AW-1:0]];
  assign push = tok_valid && !full;
  assign tok_ready = !full;
  assign hs = state != IDLE;
  assign busy = hs || !empty;
  // A stale acknowledge holds IDLE off so a new request never overlaps the previous return-to-zero.
  always_comb begin
    state_d = state;
    ctl_a_d = ctl_a;
    ctl_b_d = ctl_b;
    pop = 1'b0;
    if (state == IDLE && !empty && !ack_s) begin
      state_d = REQ;
      ctl_a_d = !head;
      ctl_b_d = head;
    end else if (state == REQ && ack_s) begin
      state_d = REL;
      ctl_a_d = 1'b0;
      ctl_b_d = 1'b0;
    end else if (state == REL && !ack_s) begin
      state_d = IDLE;
      pop = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctl_a <= 1'b0;
      ctl_b <= 1'b0;
      mem <= '0;
      wp <= '0;
      rp <= '0;
      sync_q <= '0;
      ph <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      ctl_a <= ctl_a_d;
      ctl_b <= ctl_b_d;
      sync_q <= {sync_q[SYNC-2:0], actl_i};
      if (push) begin
        mem[wp[AW-1:0]] <= tok_dst;
        wp <= wp + (AW+1)'(1);
      end
      if (pop) begin
        rp <= rp + (AW+1)'(1);
        cnt_a <= cnt_a + CNT_W'(!head);
        cnt_b <= cnt_b + CNT_W'(head);
      end
      // Phase timer saturates, so err fires once per stuck phase and stays clearable.
      ph <= (state_d != state) ? '0 : (hs && ph != PW'(TIMEOUT)) ? ph + PW'(1) : ph;
      err <= (hs && ph == PW'(TIMEOUT - 1)) ? 1'b1 : err_clr ? 1'b0 : err;
    end
  end
endmodule

// File: tb/tb_demux_steer_ctl.sv
// tb_demux_steer_ctl: directed stimulus against a token-queue model of the steering
// handshake, checked every cycle, plus literal expectations for each scenario.
module tb_demux_steer_ctl;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
  localparam int SYNC = 2;
  localparam int TIMEOUT = 8;
  localparam int MOD = 1 << CNT_W;
  logic clk = 1'b0, rst = 1'b0, tok_valid = 1'b0, tok_dst = 1'b0, err_clr = 1'b0;
  logic auto_ack = 1'b0, man_ack = 1'b0, resp = 1'b0, actl;
  logic tok_ready, ctl_a, ctl_b, busy, err;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  int tests = 0, fails = 0;
  bit q[$];
  bit seq[$];
  int m_ph = 0, dwell = 0, m_ca = 0, m_cb = 0;
  bit m_a = 0, m_b = 0, m_err = 0;
  bit [SYNC-1:0] sh = '0;
  assign actl = auto_ack ? resp : man_ack;
  always #5 clk = ~clk;
  demux_steer_ctl #(.DEPTH(DEPTH), .CNT_W(CNT_W), .SYNC(SYNC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_dst(tok_dst), .tok_ready(tok_ready),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .actl_i(actl), .busy(busy), .cnt_a(cnt_a), .cnt_b(cnt_b),
    .err(err), .err_clr(err_clr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic push_tok(input bit d);
    int n;
    n = 0;
    tok_dst = d;
    tok_valid = 1'b1;
    while (!tok_ready && n < 60) begin
      tick;
      n++;
    end
    if (!tok_ready) chk("push_timeout", 0, 1);
    tick;
    tok_valid = 1'b0;
  endtask
  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 80) begin
      tick;
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask
  // Model: a token queue, the ack delay line, and the step of the four-phase handshake.
  initial forever begin
    bit ack_o, acc, set;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ph = 0; dwell = 0; m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_err = 0; sh = '0;
    end else begin
      ack_o = sh[SYNC-1];
      acc = tok_valid && q.size() < DEPTH;
      set = 0;
      if (m_ph != 0) begin
        dwell++;
        set = dwell == TIMEOUT;
      end
      if (m_ph == 0 && q.size() != 0 && !ack_o) begin
        m_a = !q[0]; m_b = q[0]; m_ph = 1; dwell = 0;
      end else if (m_ph == 1 && ack_o) begin
        m_a = 0; m_b = 0; m_ph = 2; dwell = 0;
      end else if (m_ph == 2 && !ack_o) begin
        if (q.pop_front()) m_cb = (m_cb + 1) % MOD;
        else m_ca = (m_ca + 1) % MOD;
        m_ph = 0; dwell = 0;
      end
      m_err = set ? 1'b1 : err_clr ? 1'b0 : m_err;
      if (acc) q.push_back(tok_dst);
      sh = {sh[SYNC-2:0], actl};
    end
  end
  initial forever begin
    @(negedge clk);
    resp = ctl_a | ctl_b;
  end
  initial forever begin
    bit pa, pb;
    @(negedge clk);
    if (!rst) begin
      if (ctl_a && !pa) seq.push_back(1'b0);
      if (ctl_b && !pb) seq.push_back(1'b1);
    end
    pa = ctl_a;
    pb = ctl_b;
  end
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("m_ctl_a", ctl_a, m_a);
      chk("m_ctl_b", ctl_b, m_b);
      chk("m_tok_ready", tok_ready, q.size() < DEPTH);
      chk("m_busy", busy, m_ph != 0 || q.size() != 0);
      chk("m_cnt_a", cnt_a, m_ca);
      chk("m_cnt_b", cnt_b, m_cb);
      chk("m_err", err, m_err);
    end
  end
  initial begin
    bit exp_seq[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    #1 rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick; tick;
    chk("rst_ctl_a", ctl_a, 0);
    chk("rst_ctl_b", ctl_b, 0);
    chk("rst_ready", tok_ready, 1);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    // single token, responder mirrors ctl half a cycle later
    auto_ack = 1'b1;
    push_tok(1'b0);
    chk("single_ctl_a_t", ctl_a, 0);
    tick;
    chk("single_ctl_a_t1", ctl_a, 1);
    chk("single_ctl_b_t1", ctl_b, 0);
    wait_idle;
    chk("single_cnt_a", cnt_a, 1);
    chk("single_busy", busy, 0);
    // ordering and backpressure with ack held low
    auto_ack = 1'b0;
    seq.delete();
    for (int i = 0; i < 4; i++) begin
      tok_valid = 1'b1;
      tok_dst = exp_seq[i];
      tick;
    end
    chk("bp_ready_full", tok_ready, 0);
    tok_dst = exp_seq[4];
    tick; tick;
    chk("bp_refused", tok_ready, 0);
    auto_ack = 1'b1;
    push_tok(exp_seq[4]);
    wait_idle;
    chk("seq_len", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("seq_dst", seq[i], exp_seq[i]);
    chk("bp_cnt_a", cnt_a, 3);
    chk("bp_cnt_b", cnt_b, 3);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    chk("bp_err_cleared", err, 0);
    // stale ack holds the controller in IDLE
    auto_ack = 1'b0;
    man_ack = 1'b1;
    tick; tick; tick; tick;
    push_tok(1'b1);
    tick; tick; tick; tick;
    chk("stale_ctl_b", ctl_b, 0);
    chk("stale_busy", busy, 1);
    man_ack = 1'b0;
    tick; tick;
    chk("stale_ctl_b_sync", ctl_b, 0);
    tick;
    chk("stale_ctl_b_rise", ctl_b, 1);
    auto_ack = 1'b1;
    wait_idle;
    chk("stale_cnt_b", cnt_b, 4);
    // timeout: set and clear colliding leaves err set; saturated timer does not re-set
    auto_ack = 1'b0;
    push_tok(1'b0);
    for (int i = 0; i < 8; i++) tick;
    chk("to_err_before", err, 0);
    err_clr = 1'b1;
    tick;
    chk("to_err_set", err, 1);
    chk("to_ctl_held", ctl_a, 1);
    tick;
    err_clr = 1'b0;
    chk("to_err_clr", err, 0);
    tick; tick; tick;
    chk("to_err_stays_clr", err, 0);
    auto_ack = 1'b1;
    wait_idle;
    chk("to_cnt_a", cnt_a, 4);
    // counter wrap at 2^CNT_W
    for (int i = 0; i < 6; i++) push_tok(1'b1);
    wait_idle;
    chk("wrap_cnt_b", cnt_b, 2);
    // reset mid-handshake
    auto_ack = 1'b0;
    push_tok(1'b0); push_tok(1'b1); push_tok(1'b0); push_tok(1'b1);
    tick;
    chk("mid_ctl_a", ctl_a, 1);
    chk("mid_ready", tok_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctl_a", ctl_a, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt_b", cnt_b, 0);
    chk("mid_rst_ready", tok_ready, 1);
    tick; tick;
    rst = 1'b0;
    tick; tick;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt_a", cnt_a, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
